// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : instruction fetch stage (PC gen, ROM requests, output FIFO)
// Optional statistics counters: define IF_FETCH_STATS_EN
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     IF_INC        = 4,
    parameter int unsigned     IF_LATENCY    = 2,
    parameter logic [XLEN-1:0] IF_BOOT_UCODE = 32'h1000_0000,
    parameter logic [XLEN-1:0] IF_TRAP_UCODE = 32'h1000_0100,
    parameter logic [XLEN-1:0] IF_MRET_UCODE = 32'h1000_0200,
    parameter logic [XLEN-1:0] IF_MAX_ADDR   = 32'h1000_3FFF,
    parameter int unsigned     PERF_CNT_LEN  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    rom_en_o,
    output logic [XLEN-1:0]         rom_addr_o,
    input  logic [31:0]             rom_data_i,
    output logic [31:0]             instr_o,
    output logic [XLEN-1:0]         pc_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    input  logic                    trap_i,
    input  logic                    mret_i,
    input  logic                    flush_i,
    input  logic [XLEN-1:0]         flush_addr_i,
    output logic                    fault_o,
    output logic [PERF_CNT_LEN-1:0] wait_cnt_o,
    output logic [PERF_CNT_LEN-1:0] redir_cnt_o
);

    localparam int unsigned D  = IF_LATENCY + 1;
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = $clog2(D + 1);
    localparam logic [CW:0] D_W = (CW + 1)'(D);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;

    logic [IF_LATENCY-1:0] tag_v_q;
    logic [XLEN-1:0]       tag_pc_q [IF_LATENCY];

    logic [XLEN-1:0] fifo_pc_q    [D];
    logic [31:0]     fifo_instr_q [D];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic            w_redir, w_issue, w_push, w_pop, w_oor, w_credit;
    logic [XLEN-1:0] w_target;
    logic [CW:0]     w_inflight, w_occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_redir  = trap_i | mret_i | flush_i;
    assign w_target = trap_i ? IF_TRAP_UCODE :
                      mret_i ? IF_MRET_UCODE : (flush_addr_i & ~XLEN'(3));

    assign valid_o = (count_q != '0);
    assign w_pop   = valid_o & ready_i;
    assign w_push  = tag_v_q[IF_LATENCY-1];
    assign w_oor   = (next_pc_q > IF_MAX_ADDR) || (next_pc_q < IF_BOOT_UCODE);

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < IF_LATENCY; k++) begin
            w_inflight = w_inflight + {{CW{1'b0}}, tag_v_q[k]};
        end
    end

    // Credits count both buffered and outstanding words, so returns never overflow
    assign w_occ    = {1'b0, count_q} + w_inflight - {{CW{1'b0}}, w_pop};
    assign w_credit = (w_occ < D_W);

    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        w_issue   = 1'b0;
        if (w_redir) begin
            state_d   = ST_RUN;
            next_pc_d = w_target;
        end else if (state_q == ST_RUN) begin
            if (w_oor) begin
                state_d = ST_HALT;
            end else if (w_credit) begin
                w_issue   = 1'b1;
                next_pc_d = next_pc_q + XLEN'(IF_INC);
            end
        end
    end

    // Gated by rst_n so the request port is quiet while reset is held
    assign rom_en_o   = w_issue & rst_n;
    assign rom_addr_o = rom_en_o ? next_pc_q : '0;
    assign fault_o    = (state_q == ST_HALT);
    assign pc_o       = valid_o ? fifo_pc_q[rd_ptr_q]    : '0;
    assign instr_o    = valid_o ? fifo_instr_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            next_pc_q <= IF_BOOT_UCODE;
            tag_v_q   <= '0;
            for (int k = 0; k < IF_LATENCY; k++) tag_pc_q[k] <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q     <= state_d;
            next_pc_q   <= next_pc_d;
            tag_pc_q[0] <= next_pc_q;
            for (int k = 1; k < IF_LATENCY; k++) tag_pc_q[k] <= tag_pc_q[k-1];
            if (w_redir) begin
                tag_v_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                tag_v_q[0] <= w_issue;
                for (int k = 1; k < IF_LATENCY; k++) tag_v_q[k] <= tag_v_q[k-1];
                if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({w_push, w_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_redir) begin
            fifo_pc_q[wr_ptr_q]    <= tag_pc_q[IF_LATENCY-1];
            fifo_instr_q[wr_ptr_q] <= rom_data_i;
        end
    end

`ifdef IF_FETCH_STATS_EN
    logic [PERF_CNT_LEN-1:0] wait_cnt_q, redir_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (valid_o && !ready_i && !(&wait_cnt_q)) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (w_redir && !(&redir_cnt_q))            redir_cnt_q <= redir_cnt_q + 1'b1;
        end
    end

    assign wait_cnt_o  = wait_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
`else
    assign wait_cnt_o  = '0;
    assign redir_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : directed self-checking bench for if_fetch_unit
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    localparam int unsigned LAT  = 2;
    localparam logic [31:0] BOOT = 32'h1000_0000;
    localparam logic [31:0] TRAP = 32'h1000_0100;
    localparam logic [31:0] MRET = 32'h1000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        trap_i, mret_i, flush_i;
    logic [31:0] flush_addr_i;
    logic        fault_o;
    logic [63:0] wait_cnt_o, redir_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_en_o     (rom_en_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .trap_i       (trap_i),
        .mret_i       (mret_i),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .fault_o      (fault_o),
        .wait_cnt_o   (wait_cnt_o),
        .redir_cnt_o  (redir_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ROM model: fixed LAT-cycle read pipeline
    logic [31:0] a_pipe [LAT];
    logic        v_pipe [LAT];
    always @(posedge clk) begin
        a_pipe[0] <= rom_addr_o;
        v_pipe[0] <= rom_en_o;
        for (int k = 1; k < LAT; k++) begin
            a_pipe[k] <= a_pipe[k-1];
            v_pipe[k] <= v_pipe[k-1];
        end
    end
    assign rom_data_i = v_pipe[LAT-1] ? rom_word(a_pipe[LAT-1]) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (dut.count_q <= LAT + 1) else $error("output FIFO overflow, count=%0d", dut.count_q);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #3;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, valid_o, 1'b1);
        check_eq({tag, "_pc"}, pc_o, pc);
        check_eq({tag, "_instr"}, instr_o, rom_word(pc));
    endtask

    task automatic check_stats(input string tag, input logic [63:0] w, input logic [63:0] r);
`ifdef IF_FETCH_STATS_EN
        check_eq({tag, "_wait"}, wait_cnt_o, w);
        check_eq({tag, "_redir"}, redir_cnt_o, r);
`else
        check_eq({tag, "_wait"}, wait_cnt_o, 64'd0 & w);
        check_eq({tag, "_redir"}, redir_cnt_o, 64'd0 & r);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, valid_o, 1'b0);
        check_eq({tag, "_en"}, rom_en_o, 1'b0);
        check_eq({tag, "_addr"}, rom_addr_o, 32'd0);
        check_eq({tag, "_pc"}, pc_o, 32'd0);
        check_eq({tag, "_instr"}, instr_o, 32'd0);
        check_eq({tag, "_fault"}, fault_o, 1'b0);
        check_eq({tag, "_wait"}, wait_cnt_o, 64'd0);
        check_eq({tag, "_redir"}, redir_cnt_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ready_i = 1'b1;
        trap_i = 1'b0; mret_i = 1'b0; flush_i = 1'b0; flush_addr_i = '0;
        repeat (3) @(posedge clk);
        #3;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;

        // Boot stream: cycles 0..4
        for (int i = 0; i < 5; i++) begin
            check_eq("boot_en", rom_en_o, 1'b1);
            check_eq("boot_addr", rom_addr_o, BOOT + 32'(4 * i));
            if (i < 3) check_eq("boot_novalid", valid_o, 1'b0);
            else       check_head("boot_stream", BOOT + 32'(4 * (i - 3)));
            next_cycle();
        end

        // Decoder stall for 10 cycles
        ready_i = 1'b0;
        #1;
        for (int s = 0; s < 10; s++) begin
            check_head("stall_head", BOOT + 32'h8);
            check_eq("stall_en", rom_en_o, 1'b0);
            if (s == 9) check_eq("stall_depth", 64'(dut.count_q), 64'd3);
            next_cycle();
        end
        ready_i = 1'b1;
        #1;
        check_stats("stall", 64'd10, 64'd0);
        check_eq("resume_en", rom_en_o, 1'b1);
        check_eq("resume_addr", rom_addr_o, BOOT + 32'h14);
        for (int k = 0; k < 6; k++) begin
            check_head("resume", BOOT + 32'h8 + 32'(4 * k));
            next_cycle();
        end

        // Flush with two requests in flight; low address bits dropped
        flush_i = 1'b1; flush_addr_i = 32'h1000_1002;
        #1;
        check_eq("flush_en", rom_en_o, 1'b0);
        check_head("flush_pop", BOOT + 32'h20);
        next_cycle();
        flush_i = 1'b0;
        #1;
        check_eq("flush_issue_en", rom_en_o, 1'b1);
        check_eq("flush_issue_addr", rom_addr_o, 32'h1000_1000);
        check_eq("flush_drop0", valid_o, 1'b0);
        next_cycle();
        check_eq("flush_addr1", rom_addr_o, 32'h1000_1004);
        check_eq("flush_drop1", valid_o, 1'b0);
        next_cycle();
        check_eq("flush_drop2", valid_o, 1'b0);
        next_cycle();
        check_head("flush_target", 32'h1000_1000);
        check_stats("flush", 64'd0, 64'd1);

        // All redirects at once: trap has priority
        trap_i = 1'b1; mret_i = 1'b1; flush_i = 1'b1; flush_addr_i = 32'h1000_2000;
        #1;
        check_eq("prio_en", rom_en_o, 1'b0);
        next_cycle();
        trap_i = 1'b0; mret_i = 1'b0; flush_i = 1'b0;
        #1;
        check_eq("prio_addr", rom_addr_o, TRAP);
        check_eq("prio_en2", rom_en_o, 1'b1);
        check_stats("prio", 64'd0, 64'd2);
        next_cycle();
        check_eq("prio_drop1", valid_o, 1'b0);
        next_cycle();
        check_eq("prio_drop2", valid_o, 1'b0);
        next_cycle();
        check_head("prio_target", TRAP);

        // Last fetchable word, then fault
        flush_i = 1'b1; flush_addr_i = 32'h1000_3FFC;
        #1;
        next_cycle();
        flush_i = 1'b0;
        #1;
        check_eq("edge_en", rom_en_o, 1'b1);
        check_eq("edge_addr", rom_addr_o, 32'h1000_3FFC);
        next_cycle();
        check_eq("oor_en", rom_en_o, 1'b0);
        next_cycle();
        check_eq("halt_fault", fault_o, 1'b1);
        check_eq("halt_en", rom_en_o, 1'b0);
        check_eq("halt_novalid", valid_o, 1'b0);
        next_cycle();
        check_head("halt_drain", 32'h1000_3FFC);
        check_eq("halt_fault2", fault_o, 1'b1);
        next_cycle();
        check_eq("halt_empty", valid_o, 1'b0);
        check_eq("halt_en2", rom_en_o, 1'b0);
        check_eq("halt_fault3", fault_o, 1'b1);
        next_cycle();
        mret_i = 1'b1;
        #1;
        check_eq("mret_en", rom_en_o, 1'b0);
        next_cycle();
        mret_i = 1'b0;
        #1;
        check_eq("mret_fault", fault_o, 1'b0);
        check_eq("mret_en2", rom_en_o, 1'b1);
        check_eq("mret_addr", rom_addr_o, MRET);
        check_stats("mret", 64'd0, 64'd4);
        next_cycle();
        next_cycle();
        next_cycle();
        check_head("mret_target", MRET);

        // Reset while busy
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_eq("reboot_en", rom_en_o, 1'b1);
        check_eq("reboot_addr", rom_addr_o, BOOT);
        for (int j = 0; j < 3; j++) begin
            check_eq("reboot_novalid", valid_o, 1'b0);
            next_cycle();
        end
        check_head("reboot_first", BOOT);
        next_cycle();
        check_head("reboot_second", BOOT + 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage: generates the PC, issues word requests to the instruction ROM (fixed IF_LATENCY read latency) and buffers returned words.
- Presents {pc, instr} to the decoder over a valid/ready handshake.
- Handles boot, trap, mret and branch/flush redirects.
- Sits between the instruction ROM and the decoder.

Parameters:
XLEN, 32, data/address width
IF_INC, 4, PC increment per instruction
IF_LATENCY, 2, cycles from sampled rom_en_o to rom_data_i valid (>=1)
IF_BOOT_UCODE, 32'h1000_0000, PC after reset
IF_TRAP_UCODE, 32'h1000_0100, trap redirect target
IF_MRET_UCODE, 32'h1000_0200, mret redirect target
IF_MAX_ADDR, 32'h1000_3FFF, highest fetchable byte address
PERF_CNT_LEN, 64, statistics counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rom_en_o  out  1  ROM read request
rom_addr_o  out  XLEN  ROM word address (bits[1:0]=0)
rom_data_i  in  32  ROM data, valid IF_LATENCY cycles after request
instr_o  out  32  instruction to decoder
pc_o  out  XLEN  PC of instr_o
valid_o  out  1  instr_o/pc_o valid
ready_i  in  1  decoder accepts
trap_i  in  1  redirect to IF_TRAP_UCODE
mret_i  in  1  redirect to IF_MRET_UCODE
flush_i  in  1  redirect to flush_addr_i
flush_addr_i  in  XLEN  branch/jump target
fault_o  out  1  fetch halted, next PC beyond IF_MAX_ADDR
wait_cnt_o  out  PERF_CNT_LEN  stats: stalled-output cycles
redir_cnt_o  out  PERF_CNT_LEN  stats: redirects taken

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; next_pc=IF_BOOT_UCODE; FIFO empty; in-flight tags cleared; state RUN.
- Internals:
  - Output FIFO of depth D=IF_LATENCY+1, holding {pc,instr}.
  - Shift register of IF_LATENCY stages carrying {valid,pc} for each outstanding request.
- Issue rule (RUN, no redirect this cycle):
  - rom_en_o=1 and rom_addr_o=next_pc when fifo_count + inflight_count - pop < D, where pop = valid_o & ready_i.
  - On issue, next_pc += IF_INC (XLEN wrap is irrelevant; the range check below precedes it).
- Return: when the last shift stage is valid, {pc, rom_data_i} is pushed into the FIFO in that cycle.
  - The credit rule guarantees no overflow; an overflow is a design error and must be caught by a bench assertion.
- Output:
  - valid_o = FIFO non-empty; instr_o/pc_o = FIFO head.
  - The head is held stable while valid_o & !ready_i.
- Latency: first valid_o exactly IF_LATENCY+1 cycles after the first rom_en_o.
  - Sustained throughput is 1 instr/cycle while ready_i=1.
- Redirect:
  - Priority trap_i > mret_i > flush_i.
  - In the redirect cycle: FIFO flushed, all in-flight valid tags cleared (their returns are dropped), rom_en_o=0.
  - next_pc=target, with flush_addr_i[1:0] forced to 0. State returns to RUN and fault_o clears.
  - Issue at the target starts the next cycle.
  - A redirect in the same cycle as a pop or push: the redirect wins; the pop still completes for the decoder.
- Range check:
  - If next_pc > IF_MAX_ADDR or next_pc < IF_BOOT_UCODE at issue time: no issue, state HALT, fault_o=1.
  - Already-buffered instructions still drain.
  - HALT exits only on a redirect.
- States: RUN (issue per rule), HALT (no issue, fault_o=1).
- Reset mid-operation: immediate return to reset values; in-flight ROM data after reset is ignored.

Optional Feature:
IF_FETCH_STATS_EN:
- Defined:
  - wait_cnt_o increments by 1 every cycle with valid_o=1 & ready_i=0.
  - redir_cnt_o increments by 1 on every taken redirect.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset release, ready_i=1, IF_LATENCY=2:
  - rom_addr_o 0x10000000, 0x10000004, ... on consecutive cycles.
  - First valid_o at cycle 3 with pc_o=0x10000000; then 1 instr/cycle.
- ready_i=0 for 10 cycles mid-stream:
  - At most 3 entries buffered; no rom_en_o once credits are exhausted; no lost or duplicated PCs on resume.
  - With IF_FETCH_STATS_EN defined, wait_cnt_o=10.
- flush_i=1 with flush_addr_i=0x10001002 while 2 requests are in flight:
  - Stale returns are dropped.
  - Next issue is 0x10001000; valid_o shows pc_o=0x10001000 three cycles after that issue.
- trap_i, mret_i and flush_i all asserted in the same cycle:
  - Next rom_addr_o=0x10000100; redir_cnt_o +1 (stats on).
- flush_i to 0x10003FFC, ready_i=1:
  - 0x10003FFC is fetched and delivered; next_pc 0x10004000 gives fault_o=1 and no further rom_en_o.
  - A later mret_i clears fault_o and fetches 0x10000200.
- rst_n asserted while 2 requests are in flight and FIFO is non-empty:
  - All outputs 0 immediately.
  - After release, fetch restarts at 0x10000000 and no stale data appears.
